input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end stage that conditions the raw DE10-Lite KEY and SW pins before they reach the Nios accelerometer system's button and switch PIOs. Every input is synchronised and debounced. The clean levels drive the PIO export ports directly. Single-cycle press, auto-repeat, release and switch-change pulses are produced for the tank-control logic, so firmware polling never sees bounce.

## Interface
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised level must stay stable before it is accepted (20 ms at 50 MHz); must be ≥2.
- REPEAT_DELAY_CYCLES, 25000000, held time after the press pulse before the first repeat pulse.
- REPEAT_RATE_CYCLES, 5000000, spacing between subsequent repeat pulses.
- CNT_W, 25, counter width; must hold max(all three cycle parameters).

Ports:
- clk_clk  in  1  system clock (50 MHz).
- reset_reset  in  1  synchronous, active-high reset.
- key_n_raw  in  4  raw KEY pins, active-low, asynchronous.
- sw_raw  in  10  raw SW pins, asynchronous.
- button_export  out  4  debounced KEY levels, active-low; feeds button PIO.
- switch_export  out  10  debounced SW levels; feeds switch PIO.
- key_press  out  4  1-cycle pulse on debounced press (1→0).
- key_repeat  out  4  1-cycle pulse per auto-repeat while held.
- key_release  out  4  1-cycle pulse on debounced release (0→1).
- sw_change  out  10  1-cycle pulse on any debounced switch toggle.
- any_event  out  1  OR of all pulse outputs, same cycle.

## Operation
- Synchroniser: two flops per bit. On reset, key synchroniser flops = 1 and switch synchroniser flops = 0.
- Debounce: one CNT_W counter per bit (14 total), compared against that bit's stable level.
  - sync == stable: counter cleared.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable takes sync and the counter clears.
  - Any bounce back to the stable value restarts the count from 0.
- Key FSM, one per key, with states IDLE, DELAY and REPEAT and a CNT_W timer each:
  - IDLE → DELAY on stable 1→0. key_press is asserted and the timer clears.
  - DELAY: timer increments while held. At timer == REPEAT_DELAY_CYCLES-1, key_repeat is asserted, the timer clears and the FSM moves to REPEAT.
  - REPEAT: at timer == REPEAT_RATE_CYCLES-1, key_repeat is asserted and the timer clears. This repeats indefinitely.
  - DELAY/REPEAT → IDLE on stable 0→1. key_release is asserted, no key_repeat is asserted that cycle, and the timer clears.
- sw_change[i] is asserted in the same cycle switch_export[i] changes.
- Keys and switches are fully independent. Simultaneous events on different bits all pulse in the same cycle.

## Timing
- All outputs are registered.
- Reset values: button_export = 4'hF, switch_export = 0, all pulse outputs = 0, FSMs = IDLE, all counters = 0. Reset mid-debounce or mid-repeat discards all state, and no pulse is emitted on the reset cycle or the cycle after it.
- Latency, clean edge: raw change sampled at edge k → sync2 changes at k+1 → stable and pulse update at edge k+1+DEBOUNCE_CYCLES.
- The press pulse appears in the same cycle as button_export falling. The release pulse appears in the same cycle as button_export rising.
- First repeat: REPEAT_DELAY_CYCLES cycles after the press pulse. Subsequent repeats: every REPEAT_RATE_CYCLES cycles.
- Pulses are exactly 1 cycle wide. key_press and key_repeat never coincide on the same bit.
- Counters never wrap: the debounce counter saturates via the clear rule. The FSM timer is cleared on every state transition.

## Test plan
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3 throughout.
- Reset then idle: key_n_raw=F, sw_raw=0 for 50 cycles → button_export=F, switch_export=0, no pulses, any_event=0.
- Clean press on KEY0: raw bit 0 driven low at edge k → button_export=E at k+5, key_press=0001 for exactly 1 cycle, any_event=1 in that cycle.
- Bounce rejection: KEY1 toggles low 3 cycles, high 1 cycle, low 3 cycles, then high → button_export stays F, no pulses.
- Auto-repeat: KEY2 held after press pulse at cycle P → key_repeat[2] at P+10, P+13, P+16. On release, key_release[2] fires once and repeats stop.
- Simultaneous events: SW9 and SW0 set together with KEY3 pressed at the same edge → switch_export=201h, sw_change=201h and key_press=1000 all in one cycle.
- Reset mid-repeat: assert reset_reset while KEY2 is in REPEAT → outputs return to reset values next cycle. With the key still held after reset release, a fresh key_press fires after DEBOUNCE_CYCLES+1 cycles.

Source files
------------

// File: rtl/input_conditioner.sv
// Conditions raw KEY/SW pins: two-flop synchroniser, per-bit debounce, and
// single-cycle press/repeat/release/change pulses for the tank-control logic.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000,
    parameter int CNT_W               = 25
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [3:0]  key_n_raw,
    input  logic [9:0]  sw_raw,
    output logic [3:0]  button_export,
    output logic [9:0]  switch_export,
    output logic [3:0]  key_press,
    output logic [3:0]  key_repeat,
    output logic [3:0]  key_release,
    output logic [9:0]  sw_change,
    output logic        any_event
);
    // state  | meaning
    // IDLE   | key released, repeat timer parked at zero
    // DELAY  | key held, timing the initial repeat delay
    // REPEAT | key held, one repeat pulse every REPEAT_RATE_CYCLES
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} key_state_t;

    localparam int NK = 4;
    localparam int NB = 14;
    localparam logic [NB-1:0]    SYNC_RST = {10'b0, 4'hF};
    localparam logic [CNT_W-1:0] DB_TC    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_TC    = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RR_TC    = CNT_W'(REPEAT_RATE_CYCLES - 1);

    logic [NB-1:0]    raw_all;
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    stable;
    logic [NB-1:0]    accept;
    logic [CNT_W-1:0] db_cnt [NB];

    key_state_t       key_state [NK];
    logic [CNT_W-1:0] key_tmr [NK];
    logic [NK-1:0]    fall;
    logic [NK-1:0]    rise;
    logic [NK-1:0]    rep_nxt;
    logic [NB-NK-1:0] swc_nxt;

    // Keys occupy bits [3:0], switches bits [13:4] of the combined vectors.
    assign raw_all       = {sw_raw, key_n_raw};
    assign button_export = stable[NK-1:0];
    assign switch_export = stable[NB-1:NK];

    always_comb begin
        accept  = '0;
        rep_nxt = '0;
        for (int i = 0; i < NB; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (db_cnt[i] == DB_TC);
        end
        fall    = accept[NK-1:0] & stable[NK-1:0];
        rise    = accept[NK-1:0] & ~stable[NK-1:0];
        swc_nxt = accept[NB-1:NK];
        // A release wins over a repeat falling due in the same cycle.
        for (int k = 0; k < NK; k++) begin
            if (!rise[k]) begin
                if (key_state[k] == DELAY && key_tmr[k] == RD_TC) begin
                    rep_nxt[k] = 1'b1;
                end
                if (key_state[k] == REPEAT && key_tmr[k] == RR_TC) begin
                    rep_nxt[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1       <= SYNC_RST;
            sync2       <= SYNC_RST;
            stable      <= SYNC_RST;
            key_press   <= '0;
            key_repeat  <= '0;
            key_release <= '0;
            sw_change   <= '0;
            any_event   <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
            for (int k = 0; k < NK; k++) begin
                key_state[k] <= IDLE;
                key_tmr[k]   <= '0;
            end
        end else begin
            sync1       <= raw_all;
            sync2       <= sync1;
            stable      <= stable ^ accept;
            key_press   <= fall;
            key_repeat  <= rep_nxt;
            key_release <= rise;
            sw_change   <= swc_nxt;
            any_event   <= |{fall, rise, rep_nxt, swc_nxt};

            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == stable[i] || accept[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end

            for (int k = 0; k < NK; k++) begin
                case (key_state[k])
                    IDLE: begin
                        key_tmr[k] <= '0;
                        if (fall[k]) begin
                            key_state[k] <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (rise[k]) begin
                            key_state[k] <= IDLE;
                            key_tmr[k]   <= '0;
                        end else if (key_tmr[k] == RD_TC) begin
                            key_state[k] <= REPEAT;
                            key_tmr[k]   <= '0;
                        end else begin
                            key_tmr[k] <= key_tmr[k] + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (rise[k]) begin
                            key_state[k] <= IDLE;
                            key_tmr[k]   <= '0;
                        end else if (key_tmr[k] == RR_TC) begin
                            key_tmr[k] <= '0;
                        end else begin
                            key_tmr[k] <= key_tmr[k] + CNT_W'(1);
                        end
                    end
                    default: begin
                        key_state[k] <= IDLE;
                        key_tmr[k]   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus queues expected events,
// a negedge monitor pops one entry whenever any pulse output is active.
module tb_input_conditioner;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic [3:0] key_n_raw = 4'hF;
    logic [9:0] sw_raw = '0;
    logic [3:0] button_export;
    logic [9:0] switch_export;
    logic [3:0] key_press;
    logic [3:0] key_repeat;
    logic [3:0] key_release;
    logic [9:0] sw_change;
    logic       any_event;

    input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY_CYCLES(RD),
        .REPEAT_RATE_CYCLES(RR),
        .CNT_W(8)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .key_n_raw(key_n_raw),
        .sw_raw(sw_raw),
        .button_export(button_export),
        .switch_export(switch_export),
        .key_press(key_press),
        .key_repeat(key_repeat),
        .key_release(key_release),
        .sw_change(sw_change),
        .any_event(any_event)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [3:0] btn;
        logic [9:0] sw;
        logic [3:0] prs;
        logic [3:0] rep;
        logic [3:0] rel;
        logic [9:0] swc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;

    task automatic expect_ev(input int at, input logic [3:0] btn, input logic [9:0] sw,
                             input logic [3:0] prs, input logic [3:0] rep,
                             input logic [3:0] rel, input logic [9:0] swc);
        ev_t e;
        e.at = at; e.btn = btn; e.sw = sw;
        e.prs = prs; e.rep = rep; e.rel = rel; e.swc = swc;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // Monitor: every cycle with any pulse activity must match the queue head.
    ev_t m;
    always @(negedge clk_clk) begin
        if (any_event || (|key_press) || (|key_repeat) || (|key_release) || (|sw_change)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d btn=%h sw=%h prs=%b rep=%b rel=%b swc=%h any=%b",
                         cyc, button_export, switch_export, key_press, key_repeat,
                         key_release, sw_change, any_event);
            end else begin
                m = exp_q.pop_front();
                if (cyc == m.at && button_export === m.btn && switch_export === m.sw &&
                    key_press === m.prs && key_repeat === m.rep && key_release === m.rel &&
                    sw_change === m.swc && any_event === 1'b1) begin
                    n_pass++;
                end else begin
                    $display("FAIL event actual: cyc=%0d btn=%h sw=%h prs=%b rep=%b rel=%b swc=%h any=%b required: cyc=%0d btn=%h sw=%h prs=%b rep=%b rel=%b swc=%h any=1",
                             cyc, button_export, switch_export, key_press, key_repeat,
                             key_release, sw_change, any_event,
                             m.at, m.btn, m.sw, m.prs, m.rep, m.rel, m.swc);
                end
            end
        end
    end

    initial begin
        // Reset, then 50 idle cycles.
        tick(3);
        check("rst_btn", 32'(button_export), 32'hF);
        check("rst_sw", 32'(switch_export), 32'h0);
        check("rst_pulses", 32'({key_press, key_repeat, key_release, sw_change, any_event}), 32'h0);
        reset_reset = 1'b0;
        tick(50);
        check("idle_btn", 32'(button_export), 32'hF);
        check("idle_sw", 32'(switch_export), 32'h0);

        // Clean press/release on KEY0; level must not move before k+5.
        key_n_raw = 4'hE;
        expect_ev(cyc + 6, 4'hE, 10'h0, 4'b0001, 4'b0, 4'b0, 10'h0);
        tick(5);
        check("press_not_early", 32'(button_export), 32'hF);
        tick(1);
        check("press_level", 32'(button_export), 32'hE);
        tick(2);
        key_n_raw = 4'hF;
        expect_ev(cyc + 6, 4'hF, 10'h0, 4'b0, 4'b0, 4'b0001, 10'h0);
        tick(20);

        // Bounce on KEY1: no run of 4 stable cycles, so nothing is accepted.
        key_n_raw = 4'hD; tick(3);
        key_n_raw = 4'hF; tick(1);
        key_n_raw = 4'hD; tick(3);
        key_n_raw = 4'hF; tick(20);
        check("bounce_btn", 32'(button_export), 32'hF);

        // Auto-repeat on KEY2; release lands exactly on a due repeat slot.
        key_n_raw = 4'hB;
        expect_ev(cyc + 6,  4'hB, 10'h0, 4'b0100, 4'b0, 4'b0, 10'h0);
        expect_ev(cyc + 16, 4'hB, 10'h0, 4'b0, 4'b0100, 4'b0, 10'h0);
        expect_ev(cyc + 19, 4'hB, 10'h0, 4'b0, 4'b0100, 4'b0, 10'h0);
        expect_ev(cyc + 22, 4'hB, 10'h0, 4'b0, 4'b0100, 4'b0, 10'h0);
        tick(19);
        key_n_raw = 4'hF;
        expect_ev(cyc + 6, 4'hF, 10'h0, 4'b0, 4'b0, 4'b0100, 10'h0);
        tick(20);

        // SW9, SW0 and KEY3 change on the same edge.
        sw_raw = 10'h201; key_n_raw = 4'h7;
        expect_ev(cyc + 6, 4'h7, 10'h201, 4'b1000, 4'b0, 4'b0, 10'h201);
        tick(8);
        sw_raw = 10'h000; key_n_raw = 4'hF;
        expect_ev(cyc + 6, 4'hF, 10'h000, 4'b0, 4'b0, 4'b1000, 10'h201);
        tick(20);
        check("simul_sw_back", 32'(switch_export), 32'h0);

        // Reset while KEY2 is in REPEAT; key stays held through reset.
        key_n_raw = 4'hB;
        expect_ev(cyc + 6,  4'hB, 10'h0, 4'b0100, 4'b0, 4'b0, 10'h0);
        expect_ev(cyc + 16, 4'hB, 10'h0, 4'b0, 4'b0100, 4'b0, 10'h0);
        expect_ev(cyc + 19, 4'hB, 10'h0, 4'b0, 4'b0100, 4'b0, 10'h0);
        tick(20);
        reset_reset = 1'b1;
        tick(1);
        check("midrst_btn", 32'(button_export), 32'hF);
        check("midrst_pulses", 32'({key_press, key_repeat, key_release, sw_change, any_event}), 32'h0);
        reset_reset = 1'b0;
        expect_ev(cyc + 6, 4'hB, 10'h0, 4'b0100, 4'b0, 4'b0, 10'h0);
        tick(5);
        check("postrst_not_early", 32'(button_export), 32'hF);
        tick(3);
        key_n_raw = 4'hF;
        expect_ev(cyc + 6, 4'hF, 10'h0, 4'b0, 4'b0, 4'b0100, 10'h0);
        tick(20);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("final_btn", 32'(button_export), 32'hF);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
